// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - parametrised UART core: baud generator, transmitter and receiver
//
// Purpose:
//   One-clock UART core that sits between register/bus logic and the board pins.
//   A free-running baud generator produces one oversample tick every baud_div_i+1
//   clocks. The TX side serialises start, data (LSB first), optional parity and one
//   or two stop bits, each held for OVS ticks. The RX side synchronises the pin,
//   qualifies the start bit at half a bit time, then samples mid-bit every OVS
//   ticks and reports data with parity/framing flags.
//
// Optional build macro:
//   UART_LOOPBACK_EN - adds loopback_i; when high, RX listens to the internal TX
//                      line and the tx_o pin is held at idle (1).
//
// Parameters:
//   DATA_W  data bits per frame (5..9)
//   OVS     oversample ticks per bit (power of 2, >= 4)
//   DIV_W   width of the baud divisor
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   baud_div_i     tick period = baud_div_i+1 clocks, sampled live
//   parity_mode_i  00 none, 01 even, 10 odd, 11 none
//   stop2_i        1 = two stop bits on TX
//   tx_valid_i     TX request
//   tx_data_i      TX payload
//   tx_ready_o     TX can accept a word this cycle
//   tx_o           serial out, idles high
//   tx_done_o      one-cycle pulse on the last stop tick
//   rx_i           serial in, asynchronous to clk_i
//   rx_en_i        receiver enable; dropping it mid-frame aborts the frame
//   loopback_i     (UART_LOOPBACK_EN only) internal TX->RX loopback
//   rx_data_o      last received word
//   rx_valid_o     one-cycle pulse when a frame completes
//   rx_perr_o      parity error of the last frame
//   rx_ferr_o      framing error of the last frame
//   rx_busy_o      receiver is inside a frame

module uart_core_param #(
  parameter int DATA_W = 8,
  parameter int OVS    = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic [1:0]        parity_mode_i,
  input  logic              stop2_i,
  input  logic              tx_valid_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              tx_ready_o,
  output logic              tx_o,
  output logic              tx_done_o,
  input  logic              rx_i,
  input  logic              rx_en_i,
`ifdef UART_LOOPBACK_EN
  input  logic              loopback_i,
`endif
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              rx_perr_o,
  output logic              rx_ferr_o,
  output logic              rx_busy_o
);

  localparam int TCNT_W = $clog2(OVS);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(OVS - 1);
  localparam logic [TCNT_W-1:0] TICK_HALF = TCNT_W'(OVS / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == 2'b01) || (mode == 2'b10);
  endfunction

  // ---------------------------------------------------------------------------
  // Baud generator: ">=" keeps the counter moving when baud_div_i is lowered
  // below the current count.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic             tick;

  assign tick       = (baud_cnt_q >= baud_div_i);
  assign baud_cnt_d = tick ? '0 : baud_cnt_q + DIV_W'(1);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e          tx_state_q, tx_state_d;
  logic               tx_wait_q, tx_wait_d;     // accepted, waiting for tick alignment
  logic [TCNT_W-1:0]  tx_tcnt_q, tx_tcnt_d;
  logic [BIT_W-1:0]   tx_bit_q, tx_bit_d;
  logic               tx_stop_q, tx_stop_d;     // second stop bit in progress
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic               tx_par_q, tx_par_d;
  logic               tx_paren_q, tx_paren_d;
  logic               tx_stop2_q, tx_stop2_d;
  logic               tx_line_q, tx_line_d;
  logic               tx_done, tx_ready;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_wait_d  = tx_wait_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_paren_d = tx_paren_q;
    tx_stop2_d = tx_stop2_q;
    tx_line_d  = tx_line_q;
    tx_done    = 1'b0;
    tx_ready   = 1'b0;

    if ((tx_state_q != TX_IDLE) && tick) begin
      if (tx_wait_q) begin
        // First tick after accept: the start bit begins here.
        tx_wait_d = 1'b0;
        tx_line_d = 1'b0;
      end else if (tx_tcnt_q != TICK_LAST) begin
        tx_tcnt_d = tx_tcnt_q + TCNT_W'(1);
      end else begin
        tx_tcnt_d = '0;
        case (tx_state_q)
          TX_START: begin
            tx_state_d = TX_DATA;
            tx_bit_d   = '0;
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
          TX_DATA: begin
            if (tx_bit_q == BIT_LAST) begin
              if (tx_paren_q) begin
                tx_state_d = TX_PARITY;
                tx_line_d  = tx_par_q;
              end else begin
                tx_state_d = TX_STOP;
                tx_stop_d  = 1'b0;
                tx_line_d  = 1'b1;
              end
            end else begin
              tx_bit_d   = tx_bit_q + BIT_W'(1);
              tx_line_d  = tx_shift_q[0];
              tx_shift_d = tx_shift_q >> 1;
            end
          end
          TX_PARITY: begin
            tx_state_d = TX_STOP;
            tx_stop_d  = 1'b0;
            tx_line_d  = 1'b1;
          end
          TX_STOP: begin
            if (tx_stop2_q && !tx_stop_q) begin
              tx_stop_d = 1'b1;
            end else begin
              tx_state_d = TX_IDLE;
              tx_done    = 1'b1;
            end
          end
          default: tx_state_d = TX_IDLE;
        endcase
      end
    end

    // Ready in the done cycle lets a held tx_valid_i chain frames with no gap.
    tx_ready = (tx_state_q == TX_IDLE) || tx_done;

    if (tx_valid_i && tx_ready) begin
      tx_state_d = TX_START;
      tx_tcnt_d  = '0;
      tx_bit_d   = '0;
      tx_stop_d  = 1'b0;
      tx_shift_d = tx_data_i;
      tx_par_d   = (^tx_data_i) ^ (parity_mode_i == 2'b10);
      tx_paren_d = parity_on(parity_mode_i);
      tx_stop2_d = stop2_i;
      // Accepting on a tick edge starts the start bit immediately.
      tx_wait_d  = ~tick;
      tx_line_d  = ~tick;
    end
  end

  assign tx_ready_o = tx_ready;
  assign tx_done_o  = tx_done;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic               rx_src;
  logic               rx_meta_q, rx_sync_q;
  rx_state_e          rx_state_q, rx_state_d;
  logic [TCNT_W-1:0]  rx_tcnt_q, rx_tcnt_d;
  logic [BIT_W-1:0]   rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
  logic               rx_parbit_q, rx_parbit_d;
  logic               rx_paren_q, rx_paren_d;
  logic               rx_odd_q, rx_odd_d;
  logic               rx_rearm_q, rx_rearm_d;   // after a framing error, wait for line high
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_perr_q, rx_perr_d;
  logic               rx_ferr_q, rx_ferr_d;
  logic               rx_valid_q, rx_valid_d;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback_i ? tx_line_q : rx_i;
  assign tx_o   = loopback_i ? 1'b1 : tx_line_q;
`else
  assign rx_src = rx_i;
  assign tx_o   = tx_line_q;
`endif

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tcnt_d   = rx_tcnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_parbit_d = rx_parbit_q;
    rx_paren_d  = rx_paren_q;
    rx_odd_d    = rx_odd_q;
    rx_rearm_d  = rx_rearm_q;
    rx_data_d   = rx_data_q;
    rx_perr_d   = rx_perr_q;
    rx_ferr_d   = rx_ferr_q;
    rx_valid_d  = 1'b0;

    if ((rx_state_q != RX_IDLE) && !rx_en_i) begin
      rx_state_d = RX_IDLE;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_rearm_q) begin
            if (rx_sync_q) rx_rearm_d = 1'b0;
          end else if (rx_en_i && !rx_sync_q) begin
            rx_state_d = RX_START;
            rx_tcnt_d  = '0;
            rx_paren_d = parity_on(parity_mode_i);
            rx_odd_d   = (parity_mode_i == 2'b10);
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tcnt_q == TICK_HALF) begin
              rx_tcnt_d = '0;
              if (rx_sync_q) begin
                rx_state_d = RX_IDLE;   // false start
              end else begin
                rx_state_d = RX_DATA;
                rx_bit_d   = '0;
              end
            end else begin
              rx_tcnt_d = rx_tcnt_q + TCNT_W'(1);
            end
          end
        end
        default: begin
          if (tick) begin
            if (rx_tcnt_q != TICK_LAST) begin
              rx_tcnt_d = rx_tcnt_q + TCNT_W'(1);
            end else begin
              rx_tcnt_d = '0;
              case (rx_state_q)
                RX_DATA: begin
                  rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
                  if (rx_bit_q == BIT_LAST) begin
                    rx_state_d = rx_paren_q ? RX_PARITY : RX_STOP;
                  end else begin
                    rx_bit_d = rx_bit_q + BIT_W'(1);
                  end
                end
                RX_PARITY: begin
                  rx_parbit_d = rx_sync_q;
                  rx_state_d  = RX_STOP;
                end
                default: begin
                  rx_data_d  = rx_shift_q;
                  rx_perr_d  = rx_paren_q && (rx_parbit_q != ((^rx_shift_q) ^ rx_odd_q));
                  rx_ferr_d  = ~rx_sync_q;
                  rx_rearm_d = ~rx_sync_q;
                  rx_valid_d = 1'b1;
                  rx_state_d = RX_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_perr_o  = rx_perr_q;
  assign rx_ferr_o  = rx_ferr_q;
  assign rx_busy_o  = (rx_state_q != RX_IDLE);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      baud_cnt_q <= '0;
      tx_state_q <= TX_IDLE;
      tx_wait_q  <= 1'b0;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_paren_q <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      tx_state_q <= tx_state_d;
      tx_wait_q  <= tx_wait_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_paren_q <= tx_paren_d;
      tx_stop2_q <= tx_stop2_d;
      tx_line_q  <= tx_line_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_tcnt_q   <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_parbit_q <= 1'b0;
      rx_paren_q  <= 1'b0;
      rx_odd_q    <= 1'b0;
      rx_rearm_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_perr_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_meta_q   <= rx_src;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_tcnt_q   <= rx_tcnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_parbit_q <= rx_parbit_d;
      rx_paren_q  <= rx_paren_d;
      rx_odd_q    <= rx_odd_d;
      rx_rearm_q  <= rx_rearm_d;
      rx_data_q   <= rx_data_d;
      rx_perr_q   <= rx_perr_d;
      rx_ferr_q   <= rx_ferr_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// tb/tb_uart_core_param.sv - self-checking bench for uart_core_param (8-bit data, OVS=8)
//
// Ports of the DUT are driven from tasks; expected serial frames and receive
// results are built from frame-level rules (start, LSB-first data, parity, stops).

module tb_uart_core_param;

  localparam int OVS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx;
  logic        tx_done;
  logic        rx;
  logic        rx_en;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_perr;
  logic        rx_ferr;
  logic        rx_busy;
`ifdef UART_LOOPBACK_EN
  logic        loopback;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_rx_d  = 8'h00;
  logic       exp_perr  = 1'b0;
  logic       exp_ferr  = 1'b0;
  bit         exp_bits[$];

  uart_core_param #(.DATA_W(8), .OVS(OVS), .DIV_W(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .baud_div_i    (baud_div),
    .parity_mode_i (parity_mode),
    .stop2_i       (stop2),
    .tx_valid_i    (tx_valid),
    .tx_data_i     (tx_data),
    .tx_ready_o    (tx_ready),
    .tx_o          (tx),
    .tx_done_o     (tx_done),
    .rx_i          (rx),
    .rx_en_i       (rx_en),
`ifdef UART_LOOPBACK_EN
    .loopback_i    (loopback),
`endif
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_perr_o     (rx_perr),
    .rx_ferr_o     (rx_ferr),
    .rx_busy_o     (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    #1;
  endtask

  // Serial picture of one frame as it should appear on the line.
  task automatic append_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (pm == 2'b01) exp_bits.push_back(^d);
    if (pm == 2'b10) exp_bits.push_back(~^d);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
  endtask

  // Sends nfr frames (d0, then d1 back-to-back) and checks line, done and ready.
  task automatic run_tx(input logic [7:0] d0, input logic [7:0] d1, input int nfr,
                        input logic [1:0] pm, input logic s2, input int bdiv, input string tag);
    int nb, fl, lat, done_cnt, done_bad, rdy_bad;
    bit is_end;
    exp_bits.delete();
    append_frame(d0, pm, s2);
    if (nfr == 2) append_frame(d1, pm, s2);
    nb = (bdiv + 1) * OVS;
    fl = (exp_bits.size() / nfr) * nb;
    baud_div = 16'(bdiv); parity_mode = pm; stop2 = s2;
    repeat (2 * bdiv + 4) tick_cycle();
    tx_data = d0; tx_valid = 1'b1;
    lat = 0;
    while (!tx_ready && lat < 1000) begin tick_cycle(); lat++; end
    check_eq($sformatf("%s_ready_idle", tag), tx_ready, 1);
    tick_cycle();
    tx_data = d1;
    if (nfr == 1) tx_valid = 1'b0;
    check_eq($sformatf("%s_ready_drop", tag), tx_ready, 0);
    lat = 0;
    while (tx !== 1'b0 && lat < bdiv + 2) begin tick_cycle(); lat++; end
    check_eq($sformatf("%s_start_lat", tag), (lat <= bdiv), 1);
    done_cnt = 0; done_bad = 0; rdy_bad = 0;
    for (int k = 0; k <= nfr * fl + 1; k++) begin
      if (k > 0) tick_cycle();
      if (k == fl) tx_valid = 1'b0;
      if ((k % nb) == nb / 2 && (k / nb) < exp_bits.size())
        check_eq($sformatf("%s_bit%0d", tag, k / nb), tx, exp_bits[k / nb]);
      if (k < nfr * fl) begin
        is_end = ((k + 1) % fl) == 0;
        if (tx_done !== is_end) done_bad++;
        if (tx_ready !== is_end) rdy_bad++;
      end else if (tx_done) begin
        done_bad++;
      end
      if (tx_done) done_cnt++;
    end
    check_eq($sformatf("%s_done_cnt", tag), done_cnt, nfr);
    check_eq($sformatf("%s_done_timing_errs", tag), done_bad, 0);
    check_eq($sformatf("%s_ready_errs", tag), rdy_bad, 0);
    check_eq($sformatf("%s_idle_line", tag), tx, 1);
  endtask

  // Drives one frame into rx; abort_at >= 0 drops rx_en at that bit index.
  task automatic run_rx(input logic [7:0] d, input logic [1:0] pm, input bit flip,
                        input bit bad_stop, input int abort_at, input int bdiv, input string tag);
    bit q[$];
    int nb, vcnt;
    bit pen;
    logic [7:0] cap_d;
    logic cap_p, cap_f;
    pen = (pm == 2'b01) || (pm == 2'b10);
    baud_div = 16'(bdiv); parity_mode = pm;
    repeat (2 * bdiv + 4) tick_cycle();
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pen) q.push_back((^d) ^ (pm == 2'b10) ^ flip);
    q.push_back(!bad_stop);
    q.push_back(1'b1);
    q.push_back(1'b1);
    nb = (bdiv + 1) * OVS;
    vcnt = 0; cap_d = 8'h00; cap_p = 1'b0; cap_f = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) rx_en = 1'b0;
      rx = q[i];
      repeat (nb) begin
        tick_cycle();
        if (rx_valid) begin
          vcnt++; cap_d = rx_data; cap_p = rx_perr; cap_f = rx_ferr;
        end
      end
    end
    rx_en = 1'b1;
    if (abort_at >= 0) begin
      check_eq($sformatf("%s_no_valid", tag), vcnt, 0);
      check_eq($sformatf("%s_data_held", tag), rx_data, exp_rx_d);
      check_eq($sformatf("%s_perr_held", tag), rx_perr, exp_perr);
      check_eq($sformatf("%s_ferr_held", tag), rx_ferr, exp_ferr);
    end else begin
      exp_rx_d = d;
      exp_perr = pen && flip;
      exp_ferr = bad_stop;
      check_eq($sformatf("%s_valid_cnt", tag), vcnt, 1);
      check_eq($sformatf("%s_data", tag), cap_d, exp_rx_d);
      check_eq($sformatf("%s_perr", tag), cap_p, exp_perr);
      check_eq($sformatf("%s_ferr", tag), cap_f, exp_ferr);
      check_eq($sformatf("%s_data_hold", tag), rx_data, exp_rx_d);
    end
    check_eq($sformatf("%s_busy_end", tag), rx_busy, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog no finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lows, vcnt;
    bit saw_busy;
    logic [7:0] cap;

    rst_n = 1'b0; baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx = 1'b1; rx_en = 1'b1;
`ifdef UART_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) tick_cycle();
    check_eq("rst_tx", tx, 1);
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_tx_done", tx_done, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_perr", rx_perr, 0);
    check_eq("rst_rx_ferr", rx_ferr, 0);
    check_eq("rst_rx_busy", rx_busy, 0);
    rst_n = 1'b1;
    repeat (2) tick_cycle();

    // Directed TX frames.
    run_tx(8'hA5, 8'h00, 1, 2'b00, 1'b0, 3, "tx_a5_8n1");
    run_tx(8'h07, 8'h00, 1, 2'b01, 1'b1, 3, "tx_07_even_2stop");
    run_tx(8'h11, 8'h22, 2, 2'b00, 1'b0, 3, "tx_b2b");

    // Randomized TX frames.
    for (int n = 0; n < 6; n++)
      run_tx(8'($urandom), 8'h00, 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $sformatf("tx_rand%0d", n));

    // Directed RX frames.
    run_rx(8'h07, 2'b01, 1'b0, 1'b0, -1, 3, "rx_07_even");
    run_rx(8'h3C, 2'b10, 1'b1, 1'b0, -1, 3, "rx_3c_odd_flip");
    run_rx(8'h81, 2'b00, 1'b0, 1'b1, -1, 3, "rx_ferr");
    run_rx(8'h99, 2'b00, 1'b0, 1'b0,  4, 3, "rx_abort");

    // Randomized RX frames.
    for (int n = 0; n < 6; n++)
      run_rx(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), -1, $urandom_range(0, 3), $sformatf("rx_rand%0d", n));

    // Short low glitch while idle: false start, no frame.
    baud_div = 16'd3;
    repeat (10) tick_cycle();
    rx = 1'b0;
    repeat (2) tick_cycle();
    rx = 1'b1;
    saw_busy = 1'b0; vcnt = 0;
    for (int k = 0; k < 96; k++) begin
      tick_cycle();
      if (rx_busy) saw_busy = 1'b1;
      if (rx_valid) vcnt++;
      if (k == 3 + (OVS / 2 + 1) * 4) check_eq("glitch_busy_cleared", rx_busy, 0);
    end
    check_eq("glitch_saw_busy", saw_busy, 1);
    check_eq("glitch_no_valid", vcnt, 0);

    // Reset in the middle of a TX frame.
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    repeat (10) tick_cycle();
    tx_data = 8'hF0; tx_valid = 1'b1;
    tick_cycle();
    tx_valid = 1'b0;
    lat = 0;
    while (tx !== 1'b0 && lat < 8) begin tick_cycle(); lat++; end
    check_eq("rstmid_started", tx, 0);
    repeat (4 * 32 + 16) tick_cycle();
    check_eq("rstmid_bit4_low", tx, 0);
    #3 rst_n = 1'b0;
    #1;
    check_eq("rstmid_tx_async", tx, 1);
    check_eq("rstmid_done", tx_done, 0);
    tick_cycle();
    rst_n = 1'b1;
    tick_cycle();
    check_eq("rstmid_ready", tx_ready, 1);
    lows = 0;
    repeat (64) begin tick_cycle(); if (!tx) lows++; end
    check_eq("rstmid_line_idle", lows, 0);

`ifdef UART_LOOPBACK_EN
    // Loopback: TX frame is received internally, pin stays high.
    loopback = 1'b1; baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    repeat (10) tick_cycle();
    tx_data = 8'h5A; tx_valid = 1'b1;
    tick_cycle();
    tx_valid = 1'b0;
    lows = 0; vcnt = 0; cap = 8'h00;
    repeat (12 * 32) begin
      tick_cycle();
      if (!tx) lows++;
      if (rx_valid) begin vcnt++; cap = rx_data; end
    end
    check_eq("lb_pin_high", lows, 0);
    check_eq("lb_valid_cnt", vcnt, 1);
    check_eq("lb_data", cap, 8'h5A);
    loopback = 1'b0;
`else
    cap = 8'h00;
    lat = int'(cap);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
